// File: rtl/ibuff_ctrl.sv
// ibuff_ctrl_chk
//   Simulation-only checker for the instruction-buffer controller.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     push       : entries being written this cycle
//     count      : registered occupancy
module ibuff_ctrl_chk #(
  parameter int INDEX = 5
) (
  input logic             clk,
  input logic             reset,
  input logic [INDEX:0]   push,
  input logic [INDEX:0]   count
);
  localparam logic [INDEX:0] DEPTH_C = {1'b1, {INDEX{1'b0}}};

  // A push must always fit into the free space of the buffer
  a_push_fits: assert property (@(posedge clk) disable iff (reset)
    push <= (DEPTH_C - count));

  // Occupancy never exceeds the buffer depth
  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count <= DEPTH_C);
endmodule

// ibuff_ctrl
//   Control logic for the instruction buffer RAM. Holds no instruction data.
//   Fetch side compacts the lane mask into contiguous write addresses; dispatch
//   side presents head-relative read addresses for one DISP_W bundle.
//   Ports:
//     clk, reset    : clock, synchronous active-high reset
//     flush_i       : discard all buffered instructions
//     wr_mask_i     : valid lanes of the incoming fetch bundle
//     wr_en_o       : per-port RAM write enable
//     wr_addr_o     : per-port RAM write address, port p at [p*INDEX +: INDEX]
//     stall_o       : fetch must hold its bundle
//     rd_addr_o     : dispatch slot d reads head+d (mod DEPTH)
//     disp_valid_o  : a full DISP_W bundle is available at the head
//     disp_ready_i  : dispatch consumes the bundle this cycle
//     count_o       : current occupancy 0..DEPTH
module ibuff_ctrl #(
  parameter int WR_PORTS = 8,
  parameter int DISP_W   = 4,
  parameter int DEPTH    = 32,
  parameter int INDEX    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [WR_PORTS-1:0]       wr_mask_i,
  output logic [WR_PORTS-1:0]       wr_en_o,
  output logic [WR_PORTS*INDEX-1:0] wr_addr_o,
  output logic                      stall_o,
  output logic [DISP_W*INDEX-1:0]   rd_addr_o,
  output logic                      disp_valid_o,
  input  logic                      disp_ready_i,
  output logic [INDEX:0]            count_o
);
  localparam logic [INDEX:0] DEPTH_C    = (INDEX+1)'(DEPTH);
  localparam logic [INDEX:0] WR_PORTS_C = (INDEX+1)'(WR_PORTS);
  localparam logic [INDEX:0] DISP_W_C   = (INDEX+1)'(DISP_W);
  localparam logic [INDEX:0] ZERO_C     = {(INDEX+1){1'b0}};

  function automatic logic [INDEX:0] popcount_f(input logic [WR_PORTS-1:0] v);
    logic [INDEX:0] c;
    c = ZERO_C;
    for (int i = 0; i < WR_PORTS; i++) begin
      c = c + {{INDEX{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [INDEX-1:0] head_r;
  logic [INDEX-1:0] tail_r;
  logic [INDEX:0]   count_r;

  logic [INDEX:0]   free_s;
  logic             accept_s;
  logic [INDEX:0]   push_s;
  logic [INDEX:0]   pop_s;

  assign count_o = count_r;

  // Flow control: conservative stall ignores the mask popcount and any same-cycle pop
  always_comb begin
    free_s       = DEPTH_C - count_r;
    stall_o      = (free_s < WR_PORTS_C);
    accept_s     = (|wr_mask_i) & ~stall_o & ~flush_i & ~reset;
    disp_valid_o = (count_r >= DISP_W_C) & ~flush_i;
    if (accept_s) begin
      push_s = popcount_f(wr_mask_i);
    end else begin
      push_s = ZERO_C;
    end
    if (disp_valid_o && disp_ready_i) begin
      pop_s = DISP_W_C;
    end else begin
      pop_s = ZERO_C;
    end
  end

  // Write-lane compaction: each lane lands at tail plus the number of valid lanes below it
  always_comb begin
    logic [INDEX:0] pre_s;
    pre_s     = ZERO_C;
    wr_en_o   = {WR_PORTS{1'b0}};
    wr_addr_o = {(WR_PORTS*INDEX){1'b0}};
    for (int k = 0; k < WR_PORTS; k++) begin
      wr_en_o[k]                 = accept_s & wr_mask_i[k];
      wr_addr_o[k*INDEX +: INDEX] = tail_r + pre_s[INDEX-1:0];
      pre_s                      = pre_s + {{INDEX{1'b0}}, wr_mask_i[k]};
    end
  end

  // Dispatch read addresses relative to the head, wrapping mod DEPTH
  always_comb begin
    rd_addr_o = {(DISP_W*INDEX){1'b0}};
    for (int d = 0; d < DISP_W; d++) begin
      rd_addr_o[d*INDEX +: INDEX] = head_r + INDEX'(d);
    end
  end

  // Pointer and occupancy state; flush clears everything and overrides push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {INDEX{1'b0}};
      tail_r  <= {INDEX{1'b0}};
      count_r <= ZERO_C;
    end else if (flush_i) begin
      head_r  <= {INDEX{1'b0}};
      tail_r  <= {INDEX{1'b0}};
      count_r <= ZERO_C;
    end else begin
      tail_r  <= tail_r + push_s[INDEX-1:0];
      head_r  <= head_r + pop_s[INDEX-1:0];
      count_r <= count_r + push_s - pop_s;
    end
  end

  ibuff_ctrl_chk #(.INDEX(INDEX)) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .count (count_r)
  );
endmodule

// File: tb/tb_ibuff_ctrl.sv
// Scoreboard bench for ibuff_ctrl: the driver applies one directed vector per
// cycle and queues its hand-computed expectation; the monitor pops and compares
// on the falling edge.
module tb_ibuff_ctrl;
  localparam int WR_PORTS = 8;
  localparam int DISP_W   = 4;
  localparam int DEPTH    = 32;
  localparam int INDEX    = 5;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      flush_i = 1'b0;
  logic [WR_PORTS-1:0]       wr_mask_i = 8'h00;
  logic [WR_PORTS-1:0]       wr_en_o;
  logic [WR_PORTS*INDEX-1:0] wr_addr_o;
  logic                      stall_o;
  logic [DISP_W*INDEX-1:0]   rd_addr_o;
  logic                      disp_valid_o;
  logic                      disp_ready_i = 1'b0;
  logic [INDEX:0]            count_o;

  ibuff_ctrl #(.WR_PORTS(WR_PORTS), .DISP_W(DISP_W), .DEPTH(DEPTH), .INDEX(INDEX)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .wr_mask_i    (wr_mask_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .stall_o      (stall_o),
    .rd_addr_o    (rd_addr_o),
    .disp_valid_o (disp_valid_o),
    .disp_ready_i (disp_ready_i),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       rdy;
    logic [7:0] mask;
    logic [5:0] cnt;
    logic       stall;
    logic       valid;
    logic [7:0] en;
    logic [4:0] tail;
    logic [4:0] head;
  } vec_t;

  vec_t stim_q[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Expected write addresses: lane k gets tail plus count of valid lanes below k
  function automatic logic [39:0] exp_wr_addr(input logic [4:0] tail, input logic [7:0] mask);
    logic [39:0] r;
    logic [4:0]  a;
    a = tail;
    for (int k = 0; k < 8; k++) begin
      r[k*5 +: 5] = a;
      if (mask[k]) a = a + 5'd1;
    end
    return r;
  endfunction

  function automatic logic [19:0] exp_rd_addr(input logic [4:0] head);
    logic [19:0] r;
    for (int d = 0; d < 4; d++) r[d*5 +: 5] = head + 5'(d);
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic fl, input logic rdy, input logic [7:0] mask,
                   input logic [5:0] cnt, input logic stall, input logic valid, input logic [7:0] en,
                   input logic [4:0] tail, input logic [4:0] head);
    vec_t x;
    x.rst = rst; x.flush = fl; x.rdy = rdy; x.mask = mask;
    x.cnt = cnt; x.stall = stall; x.valid = valid; x.en = en;
    x.tail = tail; x.head = head;
    stim_q.push_back(x);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("count",   n_vec, 64'(count_o),      64'(e.cnt));
      chk("stall",   n_vec, 64'(stall_o),      64'(e.stall));
      chk("valid",   n_vec, 64'(disp_valid_o), 64'(e.valid));
      chk("wr_en",   n_vec, 64'(wr_en_o),      64'(e.en));
      chk("wr_addr", n_vec, 64'(wr_addr_o),    64'(exp_wr_addr(e.tail, e.mask)));
      chk("rd_addr", n_vec, 64'(rd_addr_o),    64'(exp_rd_addr(e.head)));
      n_vec++;
    end
  end

  initial begin
    //  rst fl rdy mask    cnt stall val en     tail head
    v(0, 0, 0, 8'h00,  6'd0,  0, 0, 8'h00, 5'd0,  5'd0);   // idle after reset
    v(0, 0, 1, 8'hA6,  6'd0,  0, 0, 8'hA6, 5'd0,  5'd0);   // sparse mask, ready ignored
    v(0, 0, 0, 8'h00,  6'd4,  0, 1, 8'h00, 5'd4,  5'd0);
    v(0, 0, 0, 8'hFF,  6'd4,  0, 1, 8'hFF, 5'd4,  5'd0);
    v(0, 0, 1, 8'h0F,  6'd12, 0, 1, 8'h0F, 5'd12, 5'd0);   // push and pop together
    v(0, 0, 0, 8'hFF,  6'd12, 0, 1, 8'hFF, 5'd16, 5'd4);
    v(0, 0, 0, 8'h1F,  6'd20, 0, 1, 8'h1F, 5'd24, 5'd4);
    v(0, 0, 0, 8'hFF,  6'd25, 1, 1, 8'h00, 5'd29, 5'd4);   // back-pressure
    v(0, 0, 1, 8'hFF,  6'd25, 1, 1, 8'h00, 5'd29, 5'd4);
    v(0, 0, 0, 8'h00,  6'd21, 0, 1, 8'h00, 5'd29, 5'd8);   // stall released
    v(0, 0, 1, 8'h01,  6'd21, 0, 1, 8'h01, 5'd29, 5'd8);
    v(0, 0, 1, 8'hFF,  6'd18, 0, 1, 8'hFF, 5'd30, 5'd12);  // tail wrap 30..5
    v(0, 0, 1, 8'h00,  6'd22, 0, 1, 8'h00, 5'd6,  5'd16);
    v(0, 0, 1, 8'h00,  6'd18, 0, 1, 8'h00, 5'd6,  5'd20);
    v(0, 0, 1, 8'h00,  6'd14, 0, 1, 8'h00, 5'd6,  5'd24);
    v(0, 0, 1, 8'h00,  6'd10, 0, 1, 8'h00, 5'd6,  5'd28);  // read 28..31
    v(0, 0, 1, 8'h00,  6'd6,  0, 1, 8'h00, 5'd6,  5'd0);   // head wrapped
    v(0, 0, 1, 8'h00,  6'd2,  0, 0, 8'h00, 5'd6,  5'd4);   // partial bundle not dispatched
    v(0, 0, 0, 8'hFF,  6'd2,  0, 0, 8'hFF, 5'd6,  5'd4);
    v(0, 0, 0, 8'hFF,  6'd10, 0, 1, 8'hFF, 5'd14, 5'd4);
    v(0, 0, 0, 8'h03,  6'd18, 0, 1, 8'h03, 5'd22, 5'd4);
    v(0, 1, 1, 8'hFF,  6'd20, 0, 0, 8'h00, 5'd24, 5'd4);   // flush
    v(0, 0, 0, 8'h00,  6'd0,  0, 0, 8'h00, 5'd0,  5'd0);
    v(0, 0, 0, 8'hFF,  6'd0,  0, 0, 8'hFF, 5'd0,  5'd0);
    v(0, 0, 0, 8'h00,  6'd8,  0, 1, 8'h00, 5'd8,  5'd0);
    v(1, 1, 1, 8'hFF,  6'd8,  0, 0, 8'h00, 5'd8,  5'd0);   // reset with flush
    v(0, 0, 0, 8'h00,  6'd0,  0, 0, 8'h00, 5'd0,  5'd0);
    v(0, 0, 0, 8'hFF,  6'd0,  0, 0, 8'hFF, 5'd0,  5'd0);
    v(1, 0, 1, 8'h0F,  6'd8,  0, 1, 8'h00, 5'd8,  5'd0);   // reset mid-fill
    v(0, 0, 0, 8'h00,  6'd0,  0, 0, 8'h00, 5'd0,  5'd0);
    v(0, 0, 0, 8'hFF,  6'd0,  0, 0, 8'hFF, 5'd0,  5'd0);   // fill to full
    v(0, 0, 0, 8'hFF,  6'd8,  0, 1, 8'hFF, 5'd8,  5'd0);
    v(0, 0, 0, 8'hFF,  6'd16, 0, 1, 8'hFF, 5'd16, 5'd0);
    v(0, 0, 0, 8'hFF,  6'd24, 0, 1, 8'hFF, 5'd24, 5'd0);
    v(0, 0, 0, 8'hFF,  6'd32, 1, 1, 8'h00, 5'd0,  5'd0);   // full
    v(0, 0, 1, 8'h00,  6'd32, 1, 1, 8'h00, 5'd0,  5'd0);
    v(0, 0, 0, 8'h00,  6'd28, 1, 1, 8'h00, 5'd0,  5'd4);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    foreach (stim_q[i]) begin
      @(posedge clk);
      #1;
      reset        = stim_q[i].rst;
      flush_i      = stim_q[i].flush;
      disp_ready_i = stim_q[i].rdy;
      wr_mask_i    = stim_q[i].mask;
      exp_q.push_back(stim_q[i]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; flush_i = 1'b0; disp_ready_i = 1'b0; wr_mask_i = 8'h00;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    if (n_vec != stim_q.size()) begin
      n_miss++;
      $display("FAIL vec_count: got %0d expected %0d", n_vec, stim_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
